// File: rtl/sd_arb_pkg.sv
//----------------------------------------------------------------------------
// sd_arb_pkg : shared types and constants for the SD DMA Wishbone arbiter.
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

package sd_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_t;

  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [2:0] WB_CTI_CONST   = 3'b001;
  localparam logic [2:0] WB_CTI_INCR    = 3'b010;
  localparam logic [2:0] WB_CTI_EOB     = 3'b111;

  localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;
  localparam logic [1:0] WB_BTE_WRAP4   = 2'b01;
  localparam logic [1:0] WB_BTE_WRAP8   = 2'b10;
  localparam logic [1:0] WB_BTE_WRAP16  = 2'b11;

  localparam int ARB_TIMEOUT_DEFAULT = 255;

endpackage

`default_nettype wire

// File: rtl/sd_wb_master_arb.sv
//----------------------------------------------------------------------------
// sd_wb_master_arb : round-robin two-requester Wishbone master arbiter with
// cycle-locked grants. Optional ack timeout: define SD_ARB_TIMEOUT_EN.
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module sd_wb_master_arb
  import sd_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] m0_wb_adr_i,
  input  logic [DW-1:0] m0_wb_dat_i,
  input  logic          m0_wb_we_i,
  input  logic          m0_wb_cyc_i,
  input  logic          m0_wb_stb_i,
  input  logic [2:0]    m0_wb_cti_i,
  input  logic [1:0]    m0_wb_bte_i,
  output logic          m0_wb_ack_o,
  output logic [DW-1:0] m0_wb_dat_o,
  output logic          m0_wb_err_o,
  input  logic [AW-1:0] m1_wb_adr_i,
  input  logic [DW-1:0] m1_wb_dat_i,
  input  logic          m1_wb_we_i,
  input  logic          m1_wb_cyc_i,
  input  logic          m1_wb_stb_i,
  input  logic [2:0]    m1_wb_cti_i,
  input  logic [1:0]    m1_wb_bte_i,
  output logic          m1_wb_ack_o,
  output logic [DW-1:0] m1_wb_dat_o,
  output logic          m1_wb_err_o,
  output logic [AW-1:0] m_wb_adr_o,
  output logic [DW-1:0] m_wb_dat_o,
  output logic          m_wb_we_o,
  output logic          m_wb_cyc_o,
  output logic          m_wb_stb_o,
  output logic [2:0]    m_wb_cti_o,
  output logic [1:0]    m_wb_bte_o,
  input  logic [DW-1:0] m_wb_dat_i,
  input  logic          m_wb_ack_i,
  output logic [1:0]    gnt_o
);

  arb_state_t r_state;
  logic       r_last;
  logic [1:0] w_req;
  logic       w_own_cyc;
  logic       w_abort;

  assign w_own_cyc = (r_state == ARB_GNT1) ? m1_wb_cyc_i : m0_wb_cyc_i;

  // Leaving a grant always passes through IDLE, so owners are separated by
  // at least one cycle with the bus cyc low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ARB_IDLE;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_req[0] && (!w_req[1] || r_last)) begin
            r_state <= ARB_GNT0;
            r_last  <= 1'b0;
          end else if (w_req[1]) begin
            r_state <= ARB_GNT1;
            r_last  <= 1'b1;
          end
        end
        ARB_GNT0, ARB_GNT1: begin
          if (!w_own_cyc || w_abort) r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

`ifdef SD_ARB_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic [1:0] r_blk;
  logic [1:0] r_err;
  logic       w_sel;

  assign w_sel   = (r_state == ARB_GNT1);
  assign w_abort = (r_state != ARB_IDLE) && w_own_cyc && m_wb_stb_o &&
                   !m_wb_ack_i && (r_cnt == 8'(TIMEOUT - 1));
  assign w_req   = {m1_wb_cyc_i & ~r_blk[1], m0_wb_cyc_i & ~r_blk[0]};

  // An aborted requester stays masked until it lets go of cyc.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 8'd0;
      r_blk <= 2'b00;
      r_err <= 2'b00;
    end else begin
      r_err <= 2'b00;
      if (r_state == ARB_IDLE || m_wb_ack_i) r_cnt <= 8'd0;
      else if (m_wb_stb_o)                   r_cnt <= r_cnt + 8'd1;
      if (!m0_wb_cyc_i) r_blk[0] <= 1'b0;
      if (!m1_wb_cyc_i) r_blk[1] <= 1'b0;
      if (w_abort) begin
        r_blk[w_sel] <= 1'b1;
        r_err[w_sel] <= 1'b1;
      end
    end
  end

  assign {m1_wb_err_o, m0_wb_err_o} = r_err;
`else
  assign w_abort = 1'b0;
  assign w_req   = {m1_wb_cyc_i, m0_wb_cyc_i};
  assign {m1_wb_err_o, m0_wb_err_o} = 2'b00;
`endif

  assign m0_wb_dat_o = m_wb_dat_i;
  assign m1_wb_dat_o = m_wb_dat_i;

  always_comb begin
    m_wb_adr_o  = '0;
    m_wb_dat_o  = '0;
    m_wb_we_o   = 1'b0;
    m_wb_cyc_o  = 1'b0;
    m_wb_stb_o  = 1'b0;
    m_wb_cti_o  = WB_CTI_CLASSIC;
    m_wb_bte_o  = WB_BTE_LINEAR;
    m0_wb_ack_o = 1'b0;
    m1_wb_ack_o = 1'b0;
    gnt_o       = 2'b00;
    case (r_state)
      ARB_GNT0: begin
        m_wb_adr_o  = m0_wb_adr_i;
        m_wb_dat_o  = m0_wb_dat_i;
        m_wb_we_o   = m0_wb_we_i;
        m_wb_cyc_o  = m0_wb_cyc_i;
        m_wb_stb_o  = m0_wb_stb_i;
        m_wb_cti_o  = m0_wb_cti_i;
        m_wb_bte_o  = m0_wb_bte_i;
        m0_wb_ack_o = m_wb_ack_i;
        gnt_o       = 2'b01;
      end
      ARB_GNT1: begin
        m_wb_adr_o  = m1_wb_adr_i;
        m_wb_dat_o  = m1_wb_dat_i;
        m_wb_we_o   = m1_wb_we_i;
        m_wb_cyc_o  = m1_wb_cyc_i;
        m_wb_stb_o  = m1_wb_stb_i;
        m_wb_cti_o  = m1_wb_cti_i;
        m_wb_bte_o  = m1_wb_bte_i;
        m1_wb_ack_o = m_wb_ack_i;
        gnt_o       = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire
